ram_param_init: RTL and testbench
=================================

RAM_PARAM_INIT -- requirements
Module: ram_param_init

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 64, word width in bits, multiple of 8.
REQ-002 ADDR_W, 8, address width; DEPTH = 2**ADDR_W words (derived, not overridable).
REQ-003 RD_LAT, 1, read latency in cycles, legal values 1 or 2.
REQ-004 Ports SHALL be (name, direction, width, meaning): clock, in, 1, single clock; all logic on rising edge.
REQ-005 reset_n, in, 1, asynchronous active-low reset.
REQ-006 req_valid, in, 1, request present.
REQ-007 req_ready, out, 1, request accepted when req_valid and req_ready are both high.
REQ-008 req_write, in, 1, 1 = write, 0 = read.
REQ-009 req_addr, in, ADDR_W, word address.
REQ-010 req_wdata, in, DATA_W, write data.
REQ-011 req_be, in, DATA_W/8, byte enables; bit i covers bits 8i+7:8i.
REQ-012 rsp_valid, out, 1, read data valid; one-cycle pulse per read.
REQ-013 rsp_rdata, out, DATA_W, read data.
REQ-014 init_start, in, 1, synchronous pulse requesting a full memory clear.
REQ-015 init_busy, out, 1, high while a clear sequence is running.

Function
REQ-016 Control SHALL be an FSM with two states: INIT and READY.
REQ-017 INIT: write all-zero to address init_cnt each cycle, starting at 0 and incrementing; req_ready=0; init_busy=1.
REQ-018 INIT SHALL go to READY in the cycle after init_cnt = DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
REQ-019 READY: req_ready=1; init_busy=0.
REQ-020 init_start=1 in READY SHALL move the FSM to INIT next cycle with init_cnt=0, and no request is accepted in that cycle.
REQ-021 init_start SHALL be ignored during INIT.
REQ-022 An accepted write SHALL update only the bytes whose req_be bit is 1; other bytes keep their value.
REQ-023 An accepted write with req_be all-zero SHALL leave memory unchanged.
REQ-024 Writes SHALL produce no response.
REQ-025 An accepted read SHALL raise rsp_valid exactly RD_LAT cycles after acceptance, with rsp_rdata = the word at req_addr.
REQ-026 Read data SHALL be the word contents before any write in the same cycle (read-first).
REQ-027 Back-to-back reads, one per cycle, SHALL be fully pipelined, giving a continuous rsp_valid train in request order.
REQ-028 A read accepted in cycle N SHALL see all writes accepted in cycles before N.
REQ-029 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-030 There is no rsp back-pressure; the consumer SHALL always accept.
REQ-031 Read responses already in the pipeline when INIT is entered SHALL still be delivered with their pre-clear data.

Reset
REQ-032 reset_n low SHALL asynchronously set: FSM=INIT, init_cnt=0, all pipeline valid bits=0, rsp_valid=0, rsp_rdata=0, req_ready=0, init_busy=1.
REQ-033 After reset_n rises, the full DEPTH-cycle clear SHALL run before the first request is accepted.
REQ-034 Memory array SHALL NOT be reset directly; it is cleared only by the INIT sequence.
REQ-035 Reset asserted mid-INIT or mid-read SHALL discard in-flight reads (no rsp_valid) and restart INIT from address 0.

Structure
REQ-036 No shared package is needed; RD_LAT legality SHALL be checked at elaboration.
REQ-037 The array and byte-enable write SHALL be one sub-module, ram_be_core (clock, we, be, waddr, wdata, raddr, rdata; registered read-first output, no reset).
REQ-038 The FSM, init counter and latency pipeline SHALL live in the top module.

Verification
REQ-039 Reset release -> init_busy=1 for exactly 256 cycles (defaults), then req_ready=1; reading addresses 0, 128 and 255 returns 0.
REQ-040 Write 0x0123456789ABCDEF to address 5 with be=0xFF, then write 0xFFFF...FF with be=0x0F, then read 5 -> rsp_rdata=0x01234567FFFFFFFF, with rsp_valid exactly RD_LAT cycles after the read.
REQ-041 Same-cycle read and write to address 9 (read in cycle N, write accepted in cycle N) -> the read returns old data; a read of address 9 in cycle N+1 returns the new data.
REQ-042 Reads of addresses 0..15 in 16 consecutive cycles with RD_LAT=2 -> 16 consecutive rsp_valid cycles with data in order.
REQ-043 init_start pulsed after writing address 3 -> req_ready low for 256 cycles; a subsequent read of 3 returns 0.
REQ-044 reset_n pulsed low at the 100th INIT cycle, and separately with a read in flight -> no rsp_valid; the full 256-cycle INIT restarts.

Source files
------------

// File: rtl/ram_param_init_pkg.sv
// ---------------------------------------------------------------------------
// ram_param_init_pkg
//
// Purpose : Shared types and constants for the self-clearing byte-enable RAM.
//           Holds the controller state encoding, the byte width used when
//           slicing words into byte lanes, and the read-latency legality test
//           used when the top module is elaborated.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ram_param_init_pkg;

    // Controller states: INIT sweeps zeros through the whole array, READY
    // serves requests.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ctrl_state_t;

    // Width of one byte lane covered by a single byte-enable bit.
    localparam int BYTE_W = 8;

    // Supported read latencies.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // True when the requested read latency is one the pipeline can build.
    function automatic logic rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_param_init_be_core.sv
// ---------------------------------------------------------------------------
// ram_be_core
//
// Purpose : Storage array with byte-enable writes and a registered,
//           read-first read port. The array has no reset; clearing is done by
//           the controller writing zeros through the normal write port.
// Ports   : clock - single clock, all logic on the rising edge
//           we    - write enable
//           be    - byte enables, bit i covers wdata[8i+7:8i]
//           waddr - write word address
//           wdata - write data
//           raddr - read word address, sampled every cycle
//           rdata - registered read data (contents before a same-edge write)
// ---------------------------------------------------------------------------
module ram_be_core
    import ram_param_init_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int LANES  = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Read and write share one edge. Because both are non-blocking, the read
    // register captures the word as it was before this edge's write, which
    // gives read-first behaviour without any bypass logic. Only the enabled
    // byte lanes are touched so the other lanes keep their old contents.
    always_ff @(posedge clock) begin
        rdata <= mem[raddr];
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

endmodule

// File: rtl/ram_param_init.sv
// ---------------------------------------------------------------------------
// ram_param_init
//
// Purpose : Single-port request RAM that clears itself to zero after reset
//           and on demand. While clearing, one word per cycle is zeroed and
//           no requests are taken. Reads return data RD_LAT cycles after
//           acceptance as a one-cycle rsp_valid pulse; writes are silent and
//           honour byte enables.
// Ports   : clock      - single clock, rising edge
//           reset_n    - asynchronous active-low reset
//           req_valid  - request present
//           req_ready  - request accepted when req_valid && req_ready
//           req_write  - 1 = write, 0 = read
//           req_addr   - word address
//           req_wdata  - write data
//           req_be     - byte enables, bit i covers bits 8i+7:8i
//           rsp_valid  - read data valid, one pulse per accepted read
//           rsp_rdata  - read data, holds its value between responses
//           init_start - pulse requesting a full clear (ignored while clearing)
//           init_busy  - high while a clear sequence runs
// ---------------------------------------------------------------------------
module ram_param_init
    import ram_param_init_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic                     init_start,
    output logic                     init_busy
);

    localparam int BE_W = DATA_W / BYTE_W;

    // Parameter sanity checks, caught when the design is elaborated.
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("ram_param_init: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
        $error("ram_param_init: DATA_W must be a multiple of 8");
    end

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [ADDR_W-1:0]  init_cnt;
    logic [ADDR_W-1:0]  init_cnt_nxt;

    logic               core_we;
    logic [BE_W-1:0]    core_be;
    logic [ADDR_W-1:0]  core_waddr;
    logic [DATA_W-1:0]  core_wdata;
    logic [DATA_W-1:0]  core_rdata;
    logic               rd_accept;

    // Controller state and clear-address counter. Reset lands in INIT at
    // address 0 so every power-up starts with a full clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next-state and datapath steering. In INIT the write port is owned by
    // the clear sweep (all lanes, zero data). In READY a pending init_start
    // wins over any request in the same cycle, so req_ready drops for that
    // cycle and the request is left for the requester to retry later.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        req_ready    = 1'b0;
        init_busy    = 1'b0;
        core_we      = 1'b0;
        core_be      = '0;
        core_waddr   = req_addr;
        core_wdata   = req_wdata;

        case (state)
            ST_INIT: begin
                init_busy  = 1'b1;
                core_we    = 1'b1;
                core_be    = '1;
                core_waddr = init_cnt;
                core_wdata = '0;
                if (init_cnt == '1) begin
                    state_nxt    = ST_READY;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (init_start) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid && req_write) begin
                        core_we = 1'b1;
                        core_be = req_be;
                    end
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    assign rd_accept = req_valid && req_ready && !req_write;

    ram_be_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock  (clock),
        .we     (core_we),
        .be     (core_be),
        .waddr  (core_waddr),
        .wdata  (core_wdata),
        .raddr  (req_addr),
        .rdata  (core_rdata)
    );

    if (RD_LAT == 1) begin : g_lat1
        logic              vld_q;
        logic [DATA_W-1:0] hold_q;

        // The core register already gives one cycle of latency, so only a
        // valid flag is needed. hold_q remembers the last delivered word so
        // rsp_rdata stays put while the core keeps reading other addresses.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                hold_q <= '0;
            end else begin
                vld_q <= rd_accept;
                if (vld_q) begin
                    hold_q <= core_rdata;
                end
            end
        end

        assign rsp_valid = vld_q;
        assign rsp_rdata = vld_q ? core_rdata : hold_q;
    end else if (RD_LAT == 2) begin : g_lat2
        logic [1:0]        vld_q;
        logic [DATA_W-1:0] data_q;

        // Second stage copies the core output one cycle after acceptance.
        // Loading only on a live stage-1 entry keeps rsp_rdata stable between
        // responses and lets back-to-back reads stream one per cycle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= '0;
                data_q <= '0;
            end else begin
                vld_q <= {vld_q[0], rd_accept};
                if (vld_q[0]) begin
                    data_q <= core_rdata;
                end
            end
        end

        assign rsp_valid = vld_q[1];
        assign rsp_rdata = data_q;
    end else begin : g_lat_none
        assign rsp_valid = 1'b0;
        assign rsp_rdata = '0;
    end

endmodule

// File: tb/tb_ram_param_init.sv
// ---------------------------------------------------------------------------
// tb_ram_param_init
//
// Purpose : Directed bench for ram_param_init. Two instances, RD_LAT=1 and
//           RD_LAT=2, share all inputs. A response monitor compares both
//           response channels every cycle against expected queues filled by
//           the stimulus tasks with hand-computed data.
// ---------------------------------------------------------------------------
module tb_ram_param_init;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        init_start;

    logic        ready1, rv1, busy1;
    logic [63:0] rd1;
    logic        ready2, rv2, busy2;
    logic [63:0] rd2;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [63:0] last1 = '0;
    logic [63:0] last2 = '0;

    always #5 clock = ~clock;

    ram_param_init #(.DATA_W(64), .ADDR_W(8), .RD_LAT(1)) dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (ready1),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rv1),
        .rsp_rdata  (rd1),
        .init_start (init_start),
        .init_busy  (busy1)
    );

    ram_param_init #(.DATA_W(64), .ADDR_W(8), .RD_LAT(2)) dut2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (ready2),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rv2),
        .rsp_rdata  (rd2),
        .init_start (init_start),
        .init_busy  (busy2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every cycle, shortly after the edge, each response channel must either
    // deliver the oldest expected read exactly on its due edge or be idle
    // with rsp_rdata still holding the last delivered word.
    always @(posedge clock) begin
        edge_cnt++;
        #1;
        if (q1.size() != 0 && q1[0].due == edge_cnt) begin
            checkOutput("rsp_valid_lat1", 64'(rv1), 64'd1);
            checkOutput("rsp_rdata_lat1", rd1, q1[0].data);
            last1 = q1[0].data;
            void'(q1.pop_front());
        end else begin
            checkOutput("rsp_idle_lat1", 64'(rv1), 64'd0);
            checkOutput("rsp_hold_lat1", rd1, last1);
        end
        if (q2.size() != 0 && q2[0].due == edge_cnt) begin
            checkOutput("rsp_valid_lat2", 64'(rv2), 64'd1);
            checkOutput("rsp_rdata_lat2", rd2, q2[0].data);
            last2 = q2[0].data;
            void'(q2.pop_front());
        end else begin
            checkOutput("rsp_idle_lat2", 64'(rv2), 64'd0);
            checkOutput("rsp_hold_lat2", rd2, last2);
        end
    end

    // Drive one cycle of request inputs at the falling edge, check req_ready
    // for both instances, and schedule the expected response of a read.
    task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a,
                                 input logic [63:0] d, input logic [7:0] be,
                                 input logic st, input logic exp_ready,
                                 input logic [63:0] exp_data);
        exp_t e;
        @(negedge clock);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_be     = be;
        init_start = st;
        #1;
        checkOutput("req_ready_lat1", 64'(ready1), 64'(exp_ready));
        checkOutput("req_ready_lat2", 64'(ready2), 64'(exp_ready));
        if (v && !w && exp_ready) begin
            e.data = exp_data;
            e.due  = edge_cnt + 1;
            q1.push_back(e);
            e.due  = edge_cnt + 2;
            q2.push_back(e);
        end
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
        applyStimulus(1'b1, 1'b1, a, d, be, 1'b0, 1'b1, 64'd0);
    endtask

    task automatic doRead(input logic [7:0] a, input logic [63:0] exp_data);
        applyStimulus(1'b1, 1'b0, a, 64'd0, 8'h00, 1'b0, 1'b1, exp_data);
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            req_valid  = 1'b0;
            init_start = 1'b0;
        end
    endtask

    // Reset-state checks for both instances while reset_n is low.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy1"},  64'(busy1),  64'd1);
        checkOutput({tag, "_ready1"}, 64'(ready1), 64'd0);
        checkOutput({tag, "_rv1"},    64'(rv1),    64'd0);
        checkOutput({tag, "_rd1"},    rd1,         64'd0);
        checkOutput({tag, "_busy2"},  64'(busy2),  64'd1);
        checkOutput({tag, "_ready2"}, 64'(ready2), 64'd0);
        checkOutput({tag, "_rv2"},    64'(rv2),    64'd0);
        checkOutput({tag, "_rd2"},    rd2,         64'd0);
    endtask

    // Assert reset asynchronously, forget anything in flight, check state.
    task automatic assertReset(input string tag);
        reset_n = 1'b0;
        q1.delete();
        q2.delete();
        last1 = '0;
        last2 = '0;
        #1;
        checkReset(tag);
    endtask

    // Count clock edges spent in INIT, starting from the first edge that
    // writes address 0. Optionally pulses init_start once at edge poke_at
    // (which must be ignored). The bound keeps the bench from hanging.
    task automatic waitInit(input string tag, input int poke_at);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #2;
            n++;
            init_start = (n == poke_at);
        end while (busy1 && n < 1000);
        init_start = 1'b0;
        checkOutput({tag, "_len"},    64'(n),      64'd256);
        checkOutput({tag, "_busy2"},  64'(busy2),  64'd0);
        checkOutput({tag, "_ready1"}, 64'(ready1), 64'd1);
        checkOutput({tag, "_ready2"}, 64'(ready2), 64'd1);
    endtask

    // Directed scenario list.
    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        init_start = 1'b0;
        #1;
        checkReset("por");
        @(negedge clock);
        reset_n = 1'b1;
        waitInit("init_por", -1);

        // Freshly cleared words read as zero.
        doRead(8'd0,   64'd0);
        doRead(8'd128, 64'd0);
        doRead(8'd255, 64'd0);

        // Byte-enable merge, empty byte-enable, and scattered lanes.
        doWrite(8'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        doWrite(8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        doRead(8'd5, 64'h0123_4567_FFFF_FFFF);
        doWrite(8'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
        doRead(8'd5, 64'h0123_4567_FFFF_FFFF);
        doWrite(8'd7, 64'h1122_3344_5566_7788, 8'h81);
        doRead(8'd7, 64'h1100_0000_0000_0088);

        // Read then write of the same word: old data, then new data.
        doWrite(8'd9, 64'h0000_0000_0000_0A0A, 8'hFF);
        idleCycles(1);
        doRead(8'd9,  64'h0000_0000_0000_0A0A);
        doWrite(8'd9, 64'h0000_0000_0000_0B0B, 8'hFF);
        doRead(8'd9,  64'h0000_0000_0000_0B0B);
        idleCycles(3);

        // Fill 0..15, stream 16 back-to-back reads, then request a clear in
        // the very next cycle alongside a read that must not be accepted.
        for (int i = 0; i < 16; i++) begin
            doWrite(8'(i), 64'(i) * 64'h0101_0101_0101_0101, 8'hFF);
        end
        for (int i = 0; i < 16; i++) begin
            doRead(8'(i), 64'(i) * 64'h0101_0101_0101_0101);
        end
        applyStimulus(1'b1, 1'b0, 8'd3, 64'd0, 8'h00, 1'b1, 1'b0, 64'd0);
        @(posedge clock);
        #2;
        init_start = 1'b0;
        req_valid  = 1'b0;
        checkOutput("start_busy1", 64'(busy1), 64'd1);
        checkOutput("start_busy2", 64'(busy2), 64'd1);
        waitInit("init_start", 50);
        doRead(8'd3,  64'd0);
        doRead(8'd15, 64'd0);
        doRead(8'd5,  64'd0);
        idleCycles(3);

        // Reset in the 100th INIT cycle restarts the full clear.
        @(negedge clock);
        assertReset("rst_a");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (99) @(posedge clock);
        @(negedge clock);
        assertReset("rst_mid_init");
        @(negedge clock);
        reset_n = 1'b1;
        waitInit("init_after_rst", -1);

        // Reset while a read is in flight: the RD_LAT=2 response is dropped.
        doWrite(8'd2, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        doRead(8'd2, 64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clock);
        #3;
        assertReset("rst_mid_read");
        @(negedge clock);
        reset_n = 1'b1;
        waitInit("init_after_rd_rst", -1);
        doRead(8'd2, 64'd0);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
